qcv_imem_responder: RTL and testbench

Instruction-memory responder for the core's req/gnt/rvalid fetch interface: the memory-side counterpart of the prefetch buffer. It holds a word-addressed instruction array, grants requests subject to an outstanding-request limit and an external stall, and returns read data in order after a fixed latency. An out-of-range or misaligned address returns an error. A separate write port loads the program. The block serves as both the simulation/FPGA instruction memory and a protocol-conformance partner for the fetch unit.

---
 rtl/qcv_imem_responder.sv | 94 +++++++++
 tb/tb_qcv_imem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qcv_imem_responder.sv
// Instruction-memory responder for the req/gnt/rvalid fetch interface.
// Word array with a loader port, fixed-latency in-order read pipeline and outstanding-request limit.
module qcv_imem_responder #(
   parameter int          DEPTH_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          LATENCY         = 1,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        stall_i,
   input  logic        we_i,
   input  logic [31:0] waddr_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  outstanding_o
);

   localparam int         IDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   logic [31:0] mem [DEPTH_WORDS];

   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] err_q;
   logic [31:0]        dat_q [LATENCY];
   logic [3:0]         out_q;

   logic             gnt;
   logic             rd_in_range, rd_err, wr_ok;
   logic [IDX_W-1:0] rd_idx, wr_idx;

   // BASE_ADDR is aligned to the array size, so the range check is a tag
   // compare on the upper bits and the word index is a plain bit slice.
   assign rd_in_range = (instr_addr_i[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
   assign rd_err      = ~rd_in_range | (instr_addr_i[1:0] != 2'b00);
   assign rd_idx      = instr_addr_i[IDX_W+1:2];

   assign wr_ok  = we_i & (waddr_i[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]) & (waddr_i[1:0] == 2'b00);
   assign wr_idx = waddr_i[IDX_W+1:2];

   // Handshake: a request is accepted in any cycle with instr_req_i & instr_gnt_o;
   // each accepted request gets exactly one instr_rvalid_o pulse LATENCY cycles
   // later, in grant order. A response leaving this cycle frees its slot now.
   assign gnt = instr_req_i & ~stall_i & ((out_q - {3'b000, instr_rvalid_o}) < MAX_OUT);

   // Memory has no reset; a grant reads the old word when the loader writes it in the same cycle.
   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         mem[wr_idx] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= gnt;
         err_q[0] <= gnt & rd_err;
         dat_q[0] <= (gnt && !rd_err) ? mem[rd_idx] : 32'h0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q <= 4'd0;
      end else if (gnt && !instr_rvalid_o) begin
         out_q <= out_q + 4'd1;
      end else if (!gnt && instr_rvalid_o) begin
         out_q <= out_q - 4'd1;
      end
   end

   assign instr_gnt_o    = gnt;
   assign instr_rvalid_o = vld_q[LATENCY-1];
   assign instr_err_o    = err_q[LATENCY-1];
   assign instr_rdata_o  = dat_q[LATENCY-1];
   assign outstanding_o  = out_q;

endmodule

// File: tb/tb_qcv_imem_responder.sv
// Bench for qcv_imem_responder: four instances with different latency/limit/base
// settings, each driven by directed vectors with hand-computed responses.
module tb_qcv_imem_responder;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        rst_n  [4];
   logic        req    [4];
   logic        stall  [4];
   logic        we     [4];
   logic [31:0] addr   [4];
   logic [31:0] waddr  [4];
   logic [31:0] wdata  [4];
   logic        gnt    [4];
   logic        rvalid [4];
   logic        err    [4];
   logic [31:0] rdata  [4];
   logic [3:0]  outst  [4];

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   localparam logic [31:0] VAL_A = 32'hAAAA_0001;
   localparam logic [31:0] VAL_B = 32'hBBBB_0002;
   localparam logic [31:0] VAL_C = 32'hCCCC_0003;

   // dut0: L=1, limit 2; dut1: L=2, limit 2; dut2: L=2, limit 1; dut3: L=4, small array at 0x8000_0000
   qcv_imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
      .clk_i(clk_i), .rst_ni(rst_n[0]), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
      .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
      .stall_i(stall[0]), .we_i(we[0]), .waddr_i(waddr[0]), .wdata_i(wdata[0]), .outstanding_o(outst[0]));

   qcv_imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2), .MAX_OUTSTANDING(2)) u_dut1 (
      .clk_i(clk_i), .rst_ni(rst_n[1]), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
      .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
      .stall_i(stall[1]), .we_i(we[1]), .waddr_i(waddr[1]), .wdata_i(wdata[1]), .outstanding_o(outst[1]));

   qcv_imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2), .MAX_OUTSTANDING(1)) u_dut2 (
      .clk_i(clk_i), .rst_ni(rst_n[2]), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
      .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
      .stall_i(stall[2]), .we_i(we[2]), .waddr_i(waddr[2]), .wdata_i(wdata[2]), .outstanding_o(outst[2]));

   qcv_imem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h8000_0000), .LATENCY(4), .MAX_OUTSTANDING(2)) u_dut3 (
      .clk_i(clk_i), .rst_ni(rst_n[3]), .instr_req_i(req[3]), .instr_addr_i(addr[3]),
      .instr_gnt_o(gnt[3]), .instr_rvalid_o(rvalid[3]), .instr_rdata_o(rdata[3]), .instr_err_o(err[3]),
      .stall_i(stall[3]), .we_i(we[3]), .waddr_i(waddr[3]), .wdata_i(wdata[3]), .outstanding_o(outst[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dval(input int i);
      return 32'h1111_0000 + 32'(i);
   endfunction

   // Loader write, one cycle; returns at the next negedge with we dropped.
   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
      we[d]    = 1'b1;
      waddr[d] = a;
      wdata[d] = v;
      @(negedge clk_i);
      we[d] = 1'b0;
   endtask

   // Pops the scoreboard for instance d when it shows a response.
   task automatic sb_pop(input string tag, input int d);
      if (rvalid[d]) begin
         if (exp_q.size() == 0) chk({tag, "_unexpected"}, 32'(rvalid[d]), 32'd0);
         else                   chk(tag, rdata[d], exp_q.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int issued;
      bit seen;
      logic [3:0] exp_out [7];
      exp_out = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};

      for (int d = 0; d < 4; d++) begin
         rst_n[d] = 1'b0; req[d] = 1'b0; stall[d] = 1'b0; we[d] = 1'b0;
         addr[d] = '0; waddr[d] = '0; wdata[d] = '0;
      end

      // ---- reset behaviour ----
      @(negedge clk_i);
      req[0] = 1'b1; addr[0] = 32'h0; #1;
      chk("rst_gnt",    32'(gnt[0]),    32'd1);
      chk("rst_rvalid", 32'(rvalid[0]), 32'd0);
      chk("rst_rdata",  rdata[0],       32'h0);
      chk("rst_err",    32'(err[0]),    32'd0);
      chk("rst_outst",  32'(outst[0]),  32'd0);
      @(negedge clk_i); #1;
      chk("rst_discard_rvalid", 32'(rvalid[0]), 32'd0);
      chk("rst_discard_outst",  32'(outst[0]),  32'd0);
      req[0] = 1'b0;
      for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
      @(negedge clk_i);

      // ---- program load ----
      wr(0, 32'h0, 32'h0000_0013);
      wr(0, 32'h4, VAL_A);
      for (int i = 0; i < 4; i++) begin
         wr(1, 32'(4 * i), dval(i));
         wr(2, 32'(4 * i), dval(i));
      end
      wr(3, 32'h8000_0004, 32'hCAFE_0001);
      wr(3, 32'h8000_0008, 32'hCAFE_0002);

      // ---- single fetch, latency 1 ----
      req[0] = 1'b1; addr[0] = 32'h0; #1;
      chk("t1_gnt",   32'(gnt[0]),   32'd1);
      chk("t1_outst0", 32'(outst[0]), 32'd0);
      @(negedge clk_i); req[0] = 1'b0; #1;
      chk("t1_rvalid", 32'(rvalid[0]), 32'd1);
      chk("t1_rdata",  rdata[0],       32'h0000_0013);
      chk("t1_err",    32'(err[0]),    32'd0);
      chk("t1_outst1", 32'(outst[0]),  32'd1);
      @(negedge clk_i); #1;
      chk("t1_rvalid_off", 32'(rvalid[0]), 32'd0);
      chk("t1_outst2",     32'(outst[0]),  32'd0);

      // ---- error responses: one past the end, then misaligned ----
      @(negedge clk_i);
      req[0] = 1'b1; addr[0] = 32'h0000_1000; #1;
      chk("err_oor_gnt", 32'(gnt[0]), 32'd1);
      @(negedge clk_i); addr[0] = 32'h0000_0002; #1;
      chk("err_mis_gnt",    32'(gnt[0]),    32'd1);
      chk("err_oor_rvalid", 32'(rvalid[0]), 32'd1);
      chk("err_oor_err",    32'(err[0]),    32'd1);
      chk("err_oor_rdata",  rdata[0],       32'h0);
      @(negedge clk_i); req[0] = 1'b0; #1;
      chk("err_mis_rvalid", 32'(rvalid[0]), 32'd1);
      chk("err_mis_err",    32'(err[0]),    32'd1);
      chk("err_mis_rdata",  rdata[0],       32'h0);
      @(negedge clk_i); #1;
      chk("err_done_outst", 32'(outst[0]), 32'd0);

      // ---- read-before-write, then dropped bad writes ----
      @(negedge clk_i);
      req[0] = 1'b1; addr[0] = 32'h4;
      we[0] = 1'b1; waddr[0] = 32'h4; wdata[0] = VAL_B; #1;
      chk("rbw_gnt", 32'(gnt[0]), 32'd1);
      @(negedge clk_i); we[0] = 1'b0; #1;
      chk("rbw_old_rdata", rdata[0], VAL_A);
      chk("rbw_gnt2",      32'(gnt[0]), 32'd1);
      @(negedge clk_i); req[0] = 1'b0; #1;
      chk("rbw_new_rdata", rdata[0], VAL_B);
      @(negedge clk_i);
      wr(0, 32'h0000_0006, VAL_C);
      wr(0, 32'h0000_1004, VAL_C);
      req[0] = 1'b1; addr[0] = 32'h4;
      @(negedge clk_i); req[0] = 1'b0; #1;
      chk("bad_wr_kept", rdata[0], VAL_B);
      @(negedge clk_i);

      // ---- back-to-back fetch, latency 2, limit 2 ----
      for (int k = 0; k < 7; k++) begin
         req[1] = (k < 4); addr[1] = 32'(4 * k); #1;
         if (k < 4) begin
            chk("tp_gnt", 32'(gnt[1]), 32'd1);
            exp_q.push_back(dval(k));
         end
         chk("tp_rvalid", 32'(rvalid[1]), 32'((k >= 2) && (k < 6)));
         chk("tp_outst",  32'(outst[1]),  32'(exp_out[k]));
         sb_pop("tp_rdata", 1);
         @(negedge clk_i);
      end
      chk("tp_drain", 32'(exp_q.size()), 32'd0);

      // ---- limit 1 halves the grant rate ----
      issued = 0;
      for (int k = 0; k < 10; k++) begin
         req[2] = (issued < 4); addr[2] = 32'(4 * issued); #1;
         chk("lim1_gnt",    32'(gnt[2]),    32'((issued < 4) && (k % 2 == 0)));
         if ((issued < 4) && (k % 2 == 0)) begin
            exp_q.push_back(dval(issued));
            issued++;
         end
         chk("lim1_rvalid", 32'(rvalid[2]), 32'((k >= 2) && (k % 2 == 0)));
         sb_pop("lim1_rdata", 2);
         @(negedge clk_i);
      end
      chk("lim1_drain", 32'(exp_q.size()), 32'd0);

      // ---- stall blocks grants, not in-flight responses ----
      req[1] = 1'b1; addr[1] = 32'h0; #1;
      chk("stl_gnt0", 32'(gnt[1]), 32'd1);
      @(negedge clk_i); addr[1] = 32'h4; stall[1] = 1'b1; #1;
      chk("stl_gnt1", 32'(gnt[1]), 32'd0);
      @(negedge clk_i); #1;
      chk("stl_gnt2",   32'(gnt[1]),    32'd0);
      chk("stl_rvalid", 32'(rvalid[1]), 32'd1);
      chk("stl_rdata",  rdata[1],       dval(0));
      @(negedge clk_i); #1;
      chk("stl_gnt3",  32'(gnt[1]),  32'd0);
      chk("stl_outst", 32'(outst[1]), 32'd0);
      @(negedge clk_i); stall[1] = 1'b0; #1;
      chk("stl_gnt_after", 32'(gnt[1]), 32'd1);
      @(negedge clk_i); req[1] = 1'b0;
      @(negedge clk_i); #1;
      chk("stl_late_rdata", rdata[1], dval(1));
      @(negedge clk_i);

      // ---- reset with two fetches in flight, latency 4 ----
      req[3] = 1'b1; addr[3] = 32'h8000_0004; #1;
      chk("rf_gnt0", 32'(gnt[3]), 32'd1);
      @(negedge clk_i); addr[3] = 32'h8000_0008; #1;
      chk("rf_gnt1", 32'(gnt[3]), 32'd1);
      @(negedge clk_i); req[3] = 1'b0; #1;
      chk("rf_outst_pre", 32'(outst[3]), 32'd2);
      rst_n[3] = 1'b0; #1;
      chk("rf_outst_rst", 32'(outst[3]), 32'd0);
      @(negedge clk_i); rst_n[3] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1; if (rvalid[3]) seen = 1'b1;
         @(negedge clk_i);
      end
      chk("rf_no_rvalid", 32'(seen), 32'd0);
      chk("rf_outst_post", 32'(outst[3]), 32'd0);
      req[3] = 1'b1; addr[3] = 32'h8000_0004;
      @(negedge clk_i); req[3] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1; if (rvalid[3]) seen = 1'b1;
         @(negedge clk_i);
      end
      #1;
      chk("rf_early_rvalid", 32'(seen), 32'd0);
      chk("rf_lat4_rvalid", 32'(rvalid[3]), 32'd1);
      chk("rf_mem_kept",    rdata[3],       32'hCAFE_0001);
      chk("rf_mem_err",     32'(err[3]),    32'd0);
      @(negedge clk_i);

      // ---- below base and one past end of offset array ----
      req[3] = 1'b1; addr[3] = 32'h7FFF_FFFC;
      @(negedge clk_i); addr[3] = 32'h8000_0040;
      @(negedge clk_i); req[3] = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i); #1;
      chk("below_err",   32'(err[3]), 32'd1);
      chk("below_rdata", rdata[3],    32'h0);
      @(negedge clk_i); #1;
      chk("past_err",    32'(err[3]),    32'd1);
      chk("past_rvalid", 32'(rvalid[3]), 32'd1);
      @(negedge clk_i);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
